// File: rtl/io_uart_leds.sv
// Memory-mapped LED register and 8N1 UART transmitter for a small core's IO page.
// Define UART_FIFO_EN to add a 4-entry transmit FIFO between the bus and the shifter.
module io_uart_leds #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic [4:0]  leds,
  output logic        uart_txd
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BaudLast = CW'(DIV - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e        r_state, w_state_d;
  logic [3:0]    r_bit_idx, w_bit_idx_d;
  logic [CW-1:0] r_baud_cnt, w_baud_cnt_d;
  logic [9:0]    r_shift, w_shift_d;
  logic [4:0]    r_leds;

  logic [1:0] w_offset;
  logic       w_wr_leds, w_wr_uart;
  logic       w_pop, w_busy, w_idle;
  logic [7:0] w_head;
  logic       w_unused;

  assign w_offset  = IO_mem_addr[3:2];
  assign w_wr_leds = IO_mem_wr && (w_offset == 2'd0);
  assign w_wr_uart = IO_mem_wr && (w_offset == 2'd1);
  assign w_unused  = ^{IO_mem_addr[31:4], IO_mem_addr[1:0], IO_mem_wdata[31:8]};

`ifdef UART_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wptr, r_rptr;
  logic [2:0] r_count;
  logic       w_full, w_empty, w_push, w_frame_end;

  assign w_full      = (r_count == 3'd4);
  assign w_empty     = (r_count == 3'd0);
  // A pop in the same edge never frees room for a write to a full FIFO.
  assign w_push      = w_wr_uart && !w_full;
  assign w_frame_end = (r_state == StSend) && (r_bit_idx == 4'd9) && (r_baud_cnt == BaudLast);
  assign w_pop       = !w_empty && ((r_state == StIdle) || w_frame_end);
  assign w_head      = r_fifo[r_rptr];
  assign w_busy      = w_full;
  assign w_idle      = (r_state == StIdle) && w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= IO_mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
    end
  end
`else
  // Unbuffered: the bus write feeds the shifter directly and only lands when idle.
  assign w_pop  = w_wr_uart && (r_state == StIdle);
  assign w_head = IO_mem_wdata[7:0];
  assign w_busy = (r_state == StSend);
  assign w_idle = (r_state == StIdle);
`endif

  always_comb begin
    w_state_d    = r_state;
    w_bit_idx_d  = r_bit_idx;
    w_baud_cnt_d = r_baud_cnt;
    w_shift_d    = r_shift;
    case (r_state)
      StIdle: begin
        if (w_pop) begin
          w_state_d    = StSend;
          w_bit_idx_d  = 4'd0;
          w_baud_cnt_d = '0;
          w_shift_d    = {1'b1, w_head, 1'b0};
        end
      end
      StSend: begin
        if (r_baud_cnt != BaudLast) begin
          w_baud_cnt_d = r_baud_cnt + CW'(1);
        end else begin
          w_baud_cnt_d = '0;
          if (r_bit_idx != 4'd9) begin
            w_bit_idx_d = r_bit_idx + 4'd1;
            w_shift_d   = {1'b1, r_shift[9:1]};
          end else if (w_pop) begin
            // Chain the next byte straight after the stop bit.
            w_bit_idx_d = 4'd0;
            w_shift_d   = {1'b1, w_head, 1'b0};
          end else begin
            w_state_d   = StIdle;
            w_bit_idx_d = 4'd0;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_bit_idx  <= 4'd0;
      r_baud_cnt <= '0;
      r_shift    <= '1;
      r_leds     <= 5'd0;
    end else begin
      r_state    <= w_state_d;
      r_bit_idx  <= w_bit_idx_d;
      r_baud_cnt <= w_baud_cnt_d;
      r_shift    <= w_shift_d;
      if (w_wr_leds) r_leds <= IO_mem_wdata[4:0];
    end
  end

  always_comb begin
    IO_mem_rdata = '0;
    case (w_offset)
      2'd0:    IO_mem_rdata = {27'b0, r_leds};
      2'd2:    IO_mem_rdata = {22'b0, w_busy, w_idle, 8'b0};
      default: IO_mem_rdata = '0;
    endcase
  end

  assign leds     = r_leds;
  assign uart_txd = (r_state == StSend) ? r_shift[0] : 1'b1;

endmodule

// File: tb/tb_io_uart_leds.sv
// Scoreboard bench for io_uart_leds at DIV=4: stimulus queues expected frames, a line
// monitor decodes uart_txd and pops/compares. Honours UART_FIFO_EN like the design.
module tb_io_uart_leds;

  localparam int DIV = 4;
`ifdef UART_FIFO_EN
  localparam int          LAT      = 2;
  localparam int          BUSY_N   = 41;
  localparam logic [31:0] BUSY_VAL = 32'h0000_0000;
`else
  localparam int          LAT      = 1;
  localparam int          BUSY_N   = 40;
  localparam logic [31:0] BUSY_VAL = 32'h0000_0200;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] rdata;
  logic [4:0]  leds;
  logic        txd;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_aborts = 0;
  bit mon_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;
  frame_t exp_q[$];

  io_uart_leds #(
    .CLK_FREQ_HZ(4),
    .BAUD_RATE  (1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .IO_mem_addr (addr),
    .IO_mem_wdata(wdata),
    .IO_mem_wr   (wr),
    .IO_mem_rdata(rdata),
    .leds        (leds),
    .uart_txd    (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_io(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic expect_frame(input logic [7:0] d, input int start);
    frame_t f;
    f.data  = d;
    f.start = start;
    exp_q.push_back(f);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Line monitor: samples every cycle on the falling edge.
  task automatic decode_frame();
    logic [9:0] bits;
    bit         shape_ok = 1'b1;
    bit         aborted = 1'b0;
    int         start = cyc;
    frame_t     e;
    mon_busy = 1'b1;
    bits = '0;
    for (int k = 0; k < 10 * DIV; k++) begin
      if (k > 0) @(negedge clk);
      if (!resetn) begin
        aborted = 1'b1;
        break;
      end
      if (k % DIV == 0) bits[k / DIV] = txd;
      else if (txd !== bits[k / DIV]) shape_ok = 1'b0;
    end
    if (aborted) begin
      n_aborts++;
    end else begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_frame: got byte %h at cycle %0d, expected no frame",
                 bits[8:1], start);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        chk("frame_data", {24'b0, bits[8:1]}, {24'b0, e.data});
        chk("frame_start_cycle", start, e.start);
        chk("frame_shape", {31'b0, shape_ok && !bits[0] && bits[9]}, 32'd1);
      end
    end
    mon_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (resetn && txd === 1'b0) decode_frame();
    end
  end

  initial begin
    int n;
    repeat (3) step();
    resetn = 1'b1;

    chk("rst_txd", txd, 1);
    chk("rst_leds", leds, 0);
    rd_chk("rst_status", 32'h8, 32'h100);
    rd_chk("rst_data_rd", 32'h4, 32'h0);
    rd_chk("rst_rsvd_rd", 32'hC, 32'h0);

    wr_io(32'h0, 32'h0000_001F);
    chk("leds_1f", leds, 5'h1F);
    rd_chk("leds_rd", 32'h0, 32'h1F);
    wr_io(32'h0, 32'hFFFF_FFE0);
    chk("leds_clear", leds, 0);
    wr_io(32'h4000_0010, 32'h0000_000A);
    chk("leds_alias_addr", leds, 5'h0A);
    wr_io(32'h8, 32'h0000_001F);
    wr_io(32'hC, 32'h0000_001F);
    chk("leds_ignore_status_rsvd", leds, 5'h0A);
    rd_chk("status_after_ignored", 32'h8, 32'h100);

    n = cyc;
    wr_io(32'h4, 32'hABCD_EF55);
    expect_frame(8'h55, n + LAT);
    for (int i = 0; i < BUSY_N; i++) begin
      rd_chk("status_during_frame", 32'h8, BUSY_VAL);
      step();
    end
    rd_chk("status_after_frame", 32'h8, 32'h100);
    drain(100);

`ifndef UART_FIFO_EN
    n = cyc;
    wr_io(32'h4, 32'h3C);
    expect_frame(8'h3C, n + 1);
    wait_cyc(n + 10);
    wr_io(32'h4, 32'hAA);
    rd_chk("status_busy_drop", 32'h8, 32'h200);
    drain(100);

    n = cyc;
    wr_io(32'h4, 32'h81);
    expect_frame(8'h81, n + 1);
    wait_cyc(n + 40);
    wr_io(32'h4, 32'h7E);
    wr_io(32'h4, 32'hE7);
    expect_frame(8'hE7, n + 42);
    drain(100);
`else
    n = cyc;
    for (int i = 0; i < 6; i++) wr_io(32'h4, 32'(i + 1));
    for (int i = 0; i < 5; i++) expect_frame(8'(i + 1), n + 2 + 40 * i);
    rd_chk("fifo_full_status", 32'h8, 32'h200);
    wait_cyc(n + 42);
    rd_chk("fifo_after_pop_status", 32'h8, 32'h0);
    drain(300);
`endif

    wr_io(32'h0, 32'h15);
    chk("leds_before_abort", leds, 5'h15);
    n = cyc;
    wr_io(32'h4, 32'h96);
    wr_io(32'h4, 32'h69);
    wait_cyc(n + LAT + 15);
    resetn = 1'b0;
    addr   = 32'h0;
    wdata  = 32'h1F;
    wr     = 1'b1;
    step();
    wr = 1'b0;
    chk("abort_txd", txd, 1);
    chk("abort_leds", leds, 0);
    rd_chk("abort_status", 32'h8, 32'h100);
    resetn = 1'b1;
    repeat (60) step();
    chk("abort_count", n_aborts, 1);
    rd_chk("post_abort_status", 32'h8, 32'h100);

    n = cyc;
    wr_io(32'h4, 32'hC3);
    expect_frame(8'hC3, n + LAT);
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_uart_leds.md
IO_UART_LEDS -- requirements
Module: io_uart_leds

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, core clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART bit rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer, truncated), DIV>=2.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port IO_mem_addr  input  32  IO byte address from the core's memory stage.
REQ-006 SHALL have port IO_mem_wdata  input  32  store data.
REQ-007 SHALL have port IO_mem_wr  input  1  one-cycle write strobe per IO store.
REQ-008 SHALL have port IO_mem_rdata  output  32  read data, combinational from IO_mem_addr and state.
REQ-009 SHALL have port leds  output  5  LED register.
REQ-010 SHALL have port uart_txd  output  1  serial line, idle high.

Function
REQ-011 SHALL decode word offset IO_mem_addr[3:2]: 0=LEDS, 1=UART_DATA, 2=UART_STATUS, 3=reserved; other address bits ignored.
REQ-012 SHALL load leds <= IO_mem_wdata[4:0] on the edge where IO_mem_wr=1 and offset=LEDS.
REQ-013 SHALL return reads: LEDS -> {27'b0,leds}; UART_DATA -> 0; UART_STATUS -> {22'b0,busy,idle,8'b0}; reserved -> 0.
REQ-014 SHALL define idle=1 when the shifter is in IDLE and no byte is pending; busy per REQ-025/REQ-027.
REQ-015 SHALL implement shifter FSM with states IDLE and SEND; 4-bit bit index, baud counter 0..DIV-1.
REQ-016 SHALL, in IDLE with a byte available, transition to SEND on the next edge and drive the start bit (0) from that cycle.
REQ-017 SHALL transmit a 10-bit frame: start 0, data bits 0..7 LSB first, stop 1; each bit held exactly DIV cycles; frame = 10*DIV cycles.
REQ-018 SHALL return to IDLE after the last cycle of the stop bit; uart_txd=1 whenever in IDLE.
REQ-019 SHALL allow back-to-back frames: a pending byte starts its start bit in the cycle immediately following the previous stop bit (no idle gap).
REQ-020 SHALL ignore writes to UART_STATUS and reserved offset; reads have no side effects.
REQ-021 SHALL take write data bits [7:0] for UART_DATA; bits [31:8] ignored.

Reset
REQ-022 SHALL, while resetn=0 at a rising edge: leds=0, FSM=IDLE, counters=0, pending storage empty, uart_txd=1 from the next cycle.
REQ-023 SHALL abort any frame in progress on reset without completing it; writes in a reset cycle are discarded.
REQ-024 SHALL present IO_mem_rdata for UART_STATUS as 0x00000100 after reset.

Configuration
REQ-025 Without UART_FIFO_EN: no buffering; a UART_DATA write is accepted only when the FSM is IDLE; otherwise dropped; busy = (FSM==SEND).
REQ-026 Without UART_FIFO_EN: a write in the final stop-bit cycle is dropped (FSM still SEND).
REQ-027 With UART_FIFO_EN: 4-entry FIFO between bus and shifter; write accepted if FIFO not full at that edge, else dropped; busy = FIFO full.
REQ-028 With UART_FIFO_EN: shifter pops the FIFO head when IDLE or at end of stop bit; push and pop on the same edge both occur; write to a full FIFO is dropped even if a pop occurs that edge; pointers wrap mod 4.

Verification
REQ-029 Reset -> uart_txd=1, leds=0, status read 0x00000100.
REQ-030 Write 0x0000001F to offset 0 -> leds=5'h1F, read offset 0 = 0x0000001F; write 0xFFFFFFE0 -> leds=0.
REQ-031 CLK_FREQ_HZ=4, BAUD_RATE=1, write 0x55 to offset 1 -> uart_txd = 0,1,0,1,0,1,0,1,0,1 each 4 cycles starting next cycle; status 0x200 for 40 cycles, then 0x100.
REQ-032 No FIFO, DIV=4: write 0x55, then 0xAA 10 cycles later -> only 0x55 frame emitted; 0xAA dropped.
REQ-033 UART_FIFO_EN, DIV=4: six consecutive-cycle writes 0x01..0x06 -> frames 0x01..0x05 back-to-back (200 cycles), 0x06 dropped; status bit9=1 after fifth write.
REQ-034 Assert resetn=0 at cycle 15 of a frame -> uart_txd=1 next cycle, FSM IDLE, FIFO empty, no remaining bits sent.
